enc_input_conditioner: RTL and testbench

//  Input stage for the PmodENC quadrature decoder: takes raw asynchronous pins A, B, BTN.

---
 rtl/enc_input_conditioner.sv | 174 +++++++++++++++++
 tb/tb_enc_input_conditioner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/enc_input_conditioner.sv
// enc_input_conditioner
//   Input stage for the PmodENC quadrature decoder. Each raw pin (A, B, BTN)
//   passes through a 2-flop synchronizer and then a per-channel debouncer.
//   The debounced level follows the synchronized pin only after the pin has
//   differed from it for DEBOUNCE_CYCLES consecutive cycles. A one-cycle
//   btn_press strobe marks every 0->1 step of BTN_clean.
//
//   Optional feature macro: ENC_GLITCH_CNT_EN
//     defined   : glitch_cnt counts rejected glitches on all channels
//                 (saturating at 8'hFF, cleared only by reset)
//     undefined : glitch_cnt is tied to 8'h00
//
//   Debouncer state per channel: ST_STABLE (clean matches the synced pin)
//   and ST_PENDING (a differing level is being timed). The state is held in
//   g_ch[n].state_q, with n = 0 for A, 1 for B and 2 for BTN.
//
//   There is no combinational path from any pin to any output: every output
//   comes straight from a flop.
module enc_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       BTN,
  output logic       A_clean,
  output logic       B_clean,
  output logic       BTN_clean,
  output logic       btn_press,
  output logic [7:0] glitch_cnt
);

  // Channel order in every 3-bit vector: bit0 = A, bit1 = B, bit2 = BTN.
  // A and B idle high; BTN idles low.
  localparam logic [2:0]       RST_VAL  = 3'b011;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [2:0] pin_raw;
  logic [2:0] s1_q;
  logic [2:0] s2_q;
  logic [2:0] clean_vec;
  logic [2:0] clean_next_vec;
  logic [2:0] reject_vec;
  logic       btn_press_q;

  assign pin_raw = {BTN, B, A};

  // Two-flop synchronizer for all three pins; only s2_q is used beyond here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= pin_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             reject;

    // Debounce state, counter and clean level for this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        clean_q <= RST_VAL[g];
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
      end
    end

    // Next state: a differing level starts the count at 1; the clean level
    // flips on the cycle the count would reach DEBOUNCE_CYCLES. A return to
    // the clean level while pending discards the count (glitch rejected).
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      reject  = 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (s2_q[g] != clean_q) begin
            state_d = ST_PENDING;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        ST_PENDING: begin
          if (s2_q[g] == clean_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            reject  = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            clean_d = s2_q[g];
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign clean_vec[g]      = clean_q;
    assign clean_next_vec[g] = clean_d;
    assign reject_vec[g]     = reject;
  end

  // Strobe registered on the same edge that BTN_clean rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_press_q <= 1'b0;
    end else begin
      btn_press_q <= ~clean_vec[2] & clean_next_vec[2];
    end
  end

  assign A_clean   = clean_vec[0];
  assign B_clean   = clean_vec[1];
  assign BTN_clean = clean_vec[2];
  assign btn_press = btn_press_q;

`ifdef ENC_GLITCH_CNT_EN
  logic [7:0] glitch_q;
  logic [7:0] glitch_d;
  logic [1:0] rej_sum;
  logic [8:0] glitch_sum;

  // Sum of same-cycle rejections across channels, saturating at 8'hFF.
  always_comb begin
    rej_sum    = {1'b0, reject_vec[0]} + {1'b0, reject_vec[1]} + {1'b0, reject_vec[2]};
    glitch_sum = {1'b0, glitch_q} + {7'b0, rej_sum};
    glitch_d   = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
  end

  // Glitch counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 8'h00;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_reject;
  assign unused_reject = ^reject_vec;
  assign glitch_cnt    = 8'h00;
`endif

endmodule

// File: tb/tb_enc_input_conditioner.sv
// tb_enc_input_conditioner
//   Directed bench for enc_input_conditioner with DEBOUNCE_CYCLES = 8.
//   A run-length model of the debounce rule (a level must be seen D times in
//   a row after a two-cycle delay) is compared against the DUT every cycle;
//   directed sequences add hand-computed literal checks of latency and counts.
module tb_enc_input_conditioner;

  localparam int D = 8;

  logic       clk;
  logic       rst_n;
  logic       A;
  logic       B;
  logic       BTN;
  logic       A_clean;
  logic       B_clean;
  logic       BTN_clean;
  logic       btn_press;
  logic [7:0] glitch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pin history (two-cycle delay), clean levels, run lengths.
  logic [2:0] m_h1;
  logic [2:0] m_h2;
  logic [2:0] m_seen;
  logic [2:0] m_clean;
  int         m_run[3];
  int         m_glitch;
  logic       m_press;

  // Observation counters taken from the DUT outputs.
  int   press_seen = 0;
  int   a_edges    = 0;
  int   b_edges    = 0;
  logic a_prev     = 1'b1;
  logic b_prev     = 1'b1;

  enc_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .BTN       (BTN),
    .A_clean   (A_clean),
    .B_clean   (B_clean),
    .BTN_clean (BTN_clean),
    .btn_press (btn_press),
    .glitch_cnt(glitch_cnt)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_glitch(input int g);
`ifdef ENC_GLITCH_CNT_EN
    return (g > 255) ? 8'hFF : 8'(g);
`else
    return (g < 0) ? 8'h01 : 8'h00;
`endif
  endfunction

  // Behavioural model, stepped on each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_h1     = 3'b011;
      m_h2     = 3'b011;
      m_clean  = 3'b011;
      m_glitch = 0;
      m_press  = 1'b0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
    end else begin
      m_seen  = m_h2;
      m_h2    = m_h1;
      m_h1    = {BTN, B, A};
      m_press = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (m_seen[c] != m_clean[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == D) begin
            if (c == 2 && m_seen[c]) m_press = 1'b1;
            m_clean[c] = m_seen[c];
            m_run[c]   = 0;
          end
        end else begin
          if (m_run[c] > 0) m_glitch++;
          m_run[c] = 0;
        end
      end
    end
  end

  // Compare process: every cycle, 3 time units after the rising edge.
  always begin
    @(posedge clk);
    #3;
    chk("a_clean",    {7'b0, A_clean},   {7'b0, m_clean[0]});
    chk("b_clean",    {7'b0, B_clean},   {7'b0, m_clean[1]});
    chk("btn_clean",  {7'b0, BTN_clean}, {7'b0, m_clean[2]});
    chk("btn_press",  {7'b0, btn_press}, {7'b0, m_press});
    chk("glitch_cnt", glitch_cnt,        exp_glitch(m_glitch));
    if (btn_press) press_seen++;
    if (A_clean != a_prev) a_edges++;
    if (B_clean != b_prev) b_edges++;
    a_prev = A_clean;
    b_prev = B_clean;
  end

  // Driver tasks: pins change on falling edges; waits end 4 units after a rising edge.
  task automatic drive(input logic a, input logic b, input logic btn);
    @(negedge clk);
    A   = a;
    B   = b;
    BTN = btn;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #4;
  endtask

  logic [2:0] cur;

  // Set one channel, then check the clean output holds for 9 edges and flips on the 10th.
  task automatic step_ch(input int ch, input logic v, input string name);
    cur     = {BTN, B, A};
    cur[ch] = v;
    drive(cur[0], cur[1], cur[2]);
    wait_edges(D + 1);
    chk({name, "_before"}, {7'b0, ((ch == 0) ? A_clean : (ch == 1) ? B_clean : BTN_clean)}, {7'b0, ~v});
    wait_edges(1);
    chk({name, "_after"}, {7'b0, ((ch == 0) ? A_clean : (ch == 1) ? B_clean : BTN_clean)}, {7'b0, v});
  endtask

  initial begin
    // 1 Reset with non-idle pins.
    rst_n = 1'b0;
    A = 1'b0; B = 1'b0; BTN = 1'b1;
    wait_edges(3);
    chk("rst_a_clean",   {7'b0, A_clean},   8'h01);
    chk("rst_b_clean",   {7'b0, B_clean},   8'h01);
    chk("rst_btn_clean", {7'b0, BTN_clean}, 8'h00);
    chk("rst_btn_press", {7'b0, btn_press}, 8'h00);
    chk("rst_glitch",    glitch_cnt,        8'h00);
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(5);

    // 2 Step on A: falls exactly 10 edges later, others unchanged.
    step_ch(0, 1'b0, "step_a");
    chk("step_b_held",   {7'b0, B_clean},   8'h01);
    chk("step_btn_held", {7'b0, BTN_clean}, 8'h00);
    step_ch(0, 1'b1, "step_a_back");
    wait_edges(2);

    // 3 Glitch on B for 5 cycles.
    drive(1'b1, 1'b0, 1'b0);
    wait_edges(5);
    drive(1'b1, 1'b1, 1'b0);
    wait_edges(12);
    chk("glitch_b_clean", {7'b0, B_clean}, 8'h01);
    chk("glitch_cnt_1",   glitch_cnt,      exp_glitch(1));

    // 4 Button bounce: 1,0,1,0,1,0 for 3 cycles each, then hold 1.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, (i % 2 == 0));
      wait_edges(3);
    end
    chk("bounce_no_press", press_seen[7:0], 8'h00);
    drive(1'b1, 1'b1, 1'b1);
    wait_edges(D + 1);
    chk("bounce_clean_low", {7'b0, BTN_clean}, 8'h00);
    wait_edges(1);
    chk("bounce_press",     {7'b0, btn_press}, 8'h01);
    chk("bounce_clean_hi",  {7'b0, BTN_clean}, 8'h01);
    wait_edges(1);
    chk("bounce_press_end", {7'b0, btn_press}, 8'h00);
    chk("bounce_glitch",    glitch_cnt,        exp_glitch(4));
    // Release: falling BTN_clean must not strobe.
    step_ch(2, 1'b0, "btn_release");
    wait_edges(2);
    chk("release_press_cnt", press_seen[7:0], 8'h01);

    // 5 Quadrature right detent, 20 cycles per step.
    a_edges = 0;
    b_edges = 0;
    step_ch(1, 1'b0, "quad_b_low");
    wait_edges(10);
    step_ch(0, 1'b0, "quad_a_low");
    wait_edges(10);
    step_ch(1, 1'b1, "quad_b_high");
    wait_edges(10);
    step_ch(0, 1'b1, "quad_a_high");
    wait_edges(10);
    chk("quad_a_edges", a_edges[7:0], 8'h02);
    chk("quad_b_edges", b_edges[7:0], 8'h02);

    // 6 Reset during a BTN rise at count 6.
    drive(1'b1, 1'b1, 1'b1);
    wait_edges(D);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_btn_clean", {7'b0, BTN_clean}, 8'h00);
    chk("midrst_btn_press", {7'b0, btn_press}, 8'h00);
    chk("midrst_glitch",    glitch_cnt,        8'h00);
    wait_edges(2);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(D + 1);
    chk("postrst_clean_low", {7'b0, BTN_clean}, 8'h00);
    wait_edges(1);
    chk("postrst_clean_hi",  {7'b0, BTN_clean}, 8'h01);
    chk("postrst_press",     {7'b0, btn_press}, 8'h01);
    wait_edges(3);
    chk("total_press_cnt",   press_seen[7:0],   8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
